// File: rtl/wb_stage.sv
// Registered writeback stage: selects rd data (ALU/load/CSR/pc+4/lui), waits on LSU for loads, drives the RF write port.
// Optional WB_FWD_EN adds fwd_pending/fwd_pending_addr for the hazard unit.
module wb_stage #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      rd_data_sel,
  input  logic [4:0]      rd_addr,
  input  logic [XLEN-1:0] r,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] lui_imm,
  input  logic [2:0]      load_funct3,
  input  logic [2:0]      load_offset,
  input  logic            lsu_rvalid,
  input  logic [XLEN-1:0] lsu_rdata,
  output logic            rf_we,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            load_err
`ifdef WB_FWD_EN
  ,
  output logic            fwd_pending,
  output logic [4:0]      fwd_pending_addr
`endif
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  localparam logic [2:0] SEL_ALU  = 3'b000;
  localparam logic [2:0] SEL_LOAD = 3'b001;
  localparam logic [2:0] SEL_CSR  = 3'b010;
  localparam logic [2:0] SEL_PC4  = 3'b011;
  localparam logic [2:0] SEL_LUI  = 3'b100;

  typedef enum logic [0:0] {IDLE, WAIT_LOAD} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [4:0]        ld_rd_reg, ld_rd_next;
  logic [2:0]        ld_f3_reg, ld_f3_next;
  logic [2:0]        ld_off_reg, ld_off_next;
  logic              rf_we_reg, rf_we_next;
  logic [4:0]        rf_waddr_reg, rf_waddr_next;
  logic [XLEN-1:0]   rf_wdata_reg, rf_wdata_next;
  logic              load_err_reg, load_err_next;

  logic [XLEN-1:0]   sel_data;
  logic [2:0]        off_eff;
  logic [XLEN-1:0]   shifted;
  logic [XLEN-1:0]   ld_data;
  logic              ld_illegal;

  always_comb begin
    sel_data = '0;
    case (rd_data_sel)
      SEL_ALU: sel_data = r;
      SEL_CSR: sel_data = csr_rdata;
      SEL_PC4: sel_data = pc + XLEN'(4);
      SEL_LUI: sel_data = lui_imm;
      default: sel_data = '0;
    endcase
  end

  // Right shift zero-fills, so lanes past the top of the word read as 0 on misaligned offsets.
  assign off_eff = (XLEN == 64) ? ld_off_reg : {1'b0, ld_off_reg[1:0]};
  assign shifted = lsu_rdata >> {off_eff, 3'b000};

  always_comb begin
    ld_data = '0;
    case (ld_f3_reg)
      3'b000:  ld_data = XLEN'($signed(shifted[7:0]));
      3'b001:  ld_data = XLEN'($signed(shifted[15:0]));
      3'b010:  ld_data = XLEN'($signed(shifted[31:0]));
      3'b011:  ld_data = shifted;
      3'b100:  ld_data = XLEN'(shifted[7:0]);
      3'b101:  ld_data = XLEN'(shifted[15:0]);
      3'b110:  ld_data = XLEN'(shifted[31:0]);
      default: ld_data = '0;
    endcase
  end

  assign ld_illegal = (ld_f3_reg == 3'b111) ||
                      ((XLEN == 32) && ((ld_f3_reg == 3'b011) || (ld_f3_reg == 3'b110)));

  assign in_ready = (state_reg == IDLE);

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    ld_rd_next    = ld_rd_reg;
    ld_f3_next    = ld_f3_reg;
    ld_off_next   = ld_off_reg;
    rf_we_next    = 1'b0;
    rf_waddr_next = rf_waddr_reg;
    rf_wdata_next = rf_wdata_reg;
    load_err_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (rd_data_sel == SEL_LOAD) begin
            ld_rd_next  = rd_addr;
            ld_f3_next  = load_funct3;
            ld_off_next = load_offset;
            cnt_next    = '0;
            state_next  = WAIT_LOAD;
          end else if (rd_addr != 5'd0) begin
            rf_we_next    = 1'b1;
            rf_waddr_next = rd_addr;
            rf_wdata_next = sel_data;
          end
        end
      end
      WAIT_LOAD: begin
        // A response in the limit cycle takes priority over the timeout.
        if (lsu_rvalid) begin
          state_next = IDLE;
          cnt_next   = '0;
          if (ld_illegal) begin
            load_err_next = 1'b1;
          end else if (ld_rd_reg != 5'd0) begin
            rf_we_next    = 1'b1;
            rf_waddr_next = ld_rd_reg;
            rf_wdata_next = ld_data;
          end
        end else if ((TIMEOUT_CYCLES > 0) && (cnt_reg == CNT_LAST)) begin
          state_next    = IDLE;
          cnt_next      = '0;
          load_err_next = 1'b1;
        end else if (TIMEOUT_CYCLES > 0) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      ld_rd_reg    <= '0;
      ld_f3_reg    <= '0;
      ld_off_reg   <= '0;
      rf_we_reg    <= 1'b0;
      rf_waddr_reg <= '0;
      rf_wdata_reg <= '0;
      load_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ld_rd_reg    <= ld_rd_next;
      ld_f3_reg    <= ld_f3_next;
      ld_off_reg   <= ld_off_next;
      rf_we_reg    <= rf_we_next;
      rf_waddr_reg <= rf_waddr_next;
      rf_wdata_reg <= rf_wdata_next;
      load_err_reg <= load_err_next;
    end
  end

  assign rf_we    = rf_we_reg;
  assign rf_waddr = rf_waddr_reg;
  assign rf_wdata = rf_wdata_reg;
  assign load_err = load_err_reg;

`ifdef WB_FWD_EN
  assign fwd_pending      = (state_reg == WAIT_LOAD);
  assign fwd_pending_addr = fwd_pending ? ld_rd_reg : 5'd0;
`endif

endmodule
